// File: rtl/fifo_to_mem_mq.sv
// fifo_to_mem_mq: drains a tagged FWFT FIFO into per-queue QDR burst-memory windows.
// Optional stats counters: define FIFO_TO_MEM_MQ_STATS_EN.
// Ports:
//   clk, rst (async, active-high), sw_rst (sync soft reset), cal_done (memory ready)
//   fifo_rd_en/fifo_data/fifo_qid/fifo_empty : FWFT FIFO read side
//   mem_ad_w_n/mem_ad_wr/mem_d_w_n/mem_bw*_n/mem_dw* : memory write port, mem_wr_full backpressure
//   q_addr_low/q_addr_high/q_enable/q_wrap   : per-queue window config (queue i at slice i)
//   q_full                                   : per-queue full flags
//   q_wr_count/q_drop_count                  : per-queue group counters (stats build only)
module fifo_to_mem_mq #(
   parameter int NUM_QUEUES      = 8,
   parameter int NUM_QUEUES_BITS = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1,
   parameter int FIFO_DATA_WIDTH = 144,
   parameter int MEM_DATA_WIDTH  = FIFO_DATA_WIDTH / 2,
   parameter int MEM_ADDR_WIDTH  = 19,
   parameter int MEM_BW_WIDTH    = 4,
   parameter int BEATS_PER_ADDR  = 2,
   parameter int BEAT_BITS       = $clog2(BEATS_PER_ADDR),
   parameter int STAT_WIDTH      = 32
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 sw_rst,
   input  logic                                 cal_done,
   output logic                                 fifo_rd_en,
   input  logic [FIFO_DATA_WIDTH-1:0]           fifo_data,
   input  logic [NUM_QUEUES_BITS-1:0]           fifo_qid,
   input  logic                                 fifo_empty,
   output logic                                 mem_ad_w_n,
   input  logic                                 mem_wr_full,
   output logic [MEM_ADDR_WIDTH-1:0]            mem_ad_wr,
   output logic                                 mem_d_w_n,
   output logic [MEM_BW_WIDTH-1:0]              mem_bwh_n,
   output logic [MEM_BW_WIDTH-1:0]              mem_bwl_n,
   output logic [MEM_DATA_WIDTH-1:0]            mem_dwl,
   output logic [MEM_DATA_WIDTH-1:0]            mem_dwh,
   input  logic [NUM_QUEUES*MEM_ADDR_WIDTH-1:0] q_addr_low,
   input  logic [NUM_QUEUES*MEM_ADDR_WIDTH-1:0] q_addr_high,
   input  logic [NUM_QUEUES-1:0]                q_enable,
   input  logic [NUM_QUEUES-1:0]                q_wrap,
   output logic [NUM_QUEUES-1:0]                q_full
`ifdef FIFO_TO_MEM_MQ_STATS_EN
   ,
   output logic [NUM_QUEUES*STAT_WIDTH-1:0]     q_wr_count,
   output logic [NUM_QUEUES*STAT_WIDTH-1:0]     q_drop_count
`endif
);
   localparam int PW = MEM_ADDR_WIDTH + BEAT_BITS;
   typedef enum logic {FIRST, REST} state_t;
   state_t st, st_nx;
   logic [BEAT_BITS-1:0] phase, phase_nx;
   logic [NUM_QUEUES_BITS-1:0] cur_q, q_in, q_sel;
   logic cur_ok, in_ok, ok_now, grp_wr, start_ok, wr_now, accept, last;
   logic [PW-1:0] ptr [NUM_QUEUES];
   logic [PW-1:0] base [NUM_QUEUES];
   logic [PW-1:0] wend [NUM_QUEUES];
   logic [MEM_ADDR_WIDTH-1:0] lo [NUM_QUEUES];
   logic [MEM_ADDR_WIDTH-1:0] hi [NUM_QUEUES];
   assign mem_bwh_n = '0;
   assign mem_bwl_n = '0;
   for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_q
      assign lo[g]   = q_addr_low[g*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
      assign hi[g]   = q_addr_high[g*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
      assign base[g] = {lo[g], {BEAT_BITS{1'b0}}};
      assign wend[g] = {hi[g], {BEAT_BITS{1'b0}}} - PW'(1);
   end
   // q_in is clamped so out-of-range qids never index past the queue arrays;
   // in_ok keeps track of whether the original id was valid.
   always_comb begin
      accept     = !fifo_empty && !mem_wr_full && cal_done;
      fifo_rd_en = accept;
      in_ok      = 32'(fifo_qid) < NUM_QUEUES;
      q_in       = in_ok ? fifo_qid : '0;
      start_ok   = in_ok && q_enable[q_in] && !q_full[q_in] && (hi[q_in] > lo[q_in]);
      q_sel      = (st == FIRST) ? q_in : cur_q;
      wr_now     = (st == FIRST) ? start_ok : grp_wr;
      ok_now     = (st == FIRST) ? in_ok : cur_ok;
      last       = phase == BEAT_BITS'(BEATS_PER_ADDR - 1);
      st_nx      = accept ? (last ? FIRST : REST) : st;
      phase_nx   = accept ? (last ? '0 : phase + BEAT_BITS'(1)) : phase;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst || sw_rst) begin
         st    <= FIRST;
         phase <= '0;
      end else begin
         st    <= st_nx;
         phase <= phase_nx;
      end
   always_ff @(posedge clk or posedge rst)
      if (rst || sw_rst) begin
         mem_ad_w_n <= 1'b1;
         mem_d_w_n  <= 1'b1;
         mem_ad_wr  <= '0;
         mem_dwl    <= '0;
         mem_dwh    <= '0;
         cur_q      <= '0;
         cur_ok     <= 1'b0;
         grp_wr     <= 1'b0;
         q_full     <= '0;
         for (int i = 0; i < NUM_QUEUES; i++) ptr[i] <= base[i];
`ifdef FIFO_TO_MEM_MQ_STATS_EN
         q_wr_count   <= '0;
         q_drop_count <= '0;
`endif
      end else begin
         mem_ad_w_n <= !(accept && wr_now && st == FIRST);
         mem_d_w_n  <= !(accept && wr_now);
         if (accept && st == FIRST) begin
            cur_q  <= q_in;
            cur_ok <= in_ok;
            grp_wr <= start_ok;
         end
         if (accept && wr_now) begin
            mem_dwl <= fifo_data[MEM_DATA_WIDTH-1:0];
            mem_dwh <= fifo_data[FIFO_DATA_WIDTH-1 -: MEM_DATA_WIDTH];
            if (st == FIRST) mem_ad_wr <= ptr[q_sel][PW-1 -: MEM_ADDR_WIDTH];
         end
         // Disable is applied after the advance so it wins on the same cycle.
         for (int i = 0; i < NUM_QUEUES; i++) begin
            if (accept && wr_now && q_sel == NUM_QUEUES_BITS'(i)) begin
               if (ptr[i] == wend[i]) begin
                  if (q_wrap[i]) ptr[i] <= base[i];
                  else q_full[i] <= 1'b1;
               end else ptr[i] <= ptr[i] + PW'(1);
            end
            if (!q_enable[i]) begin
               ptr[i]    <= base[i];
               q_full[i] <= 1'b0;
            end
         end
`ifdef FIFO_TO_MEM_MQ_STATS_EN
         if (accept && last && ok_now) begin
            if (wr_now) begin
               if (q_wr_count[q_sel*STAT_WIDTH +: STAT_WIDTH] != '1)
                  q_wr_count[q_sel*STAT_WIDTH +: STAT_WIDTH] <= q_wr_count[q_sel*STAT_WIDTH +: STAT_WIDTH] + STAT_WIDTH'(1);
            end else if (q_drop_count[q_sel*STAT_WIDTH +: STAT_WIDTH] != '1)
               q_drop_count[q_sel*STAT_WIDTH +: STAT_WIDTH] <= q_drop_count[q_sel*STAT_WIDTH +: STAT_WIDTH] + STAT_WIDTH'(1);
         end
`endif
      end
endmodule

// File: tb/tb_fifo_to_mem_mq.sv
// tb_fifo_to_mem_mq: directed bench for fifo_to_mem_mq with default parameters.
module tb_fifo_to_mem_mq;
   localparam int NQ = 8, AW = 19, FW = 144, MW = 72, BW = 4;
   logic clk = 1'b0, rst, sw_rst, cal_done, fifo_rd_en, fifo_empty, mem_ad_w_n, mem_wr_full, mem_d_w_n;
   logic [FW-1:0] fifo_data;
   logic [2:0] fifo_qid;
   logic [AW-1:0] mem_ad_wr;
   logic [BW-1:0] mem_bwh_n, mem_bwl_n;
   logic [MW-1:0] mem_dwl, mem_dwh;
   logic [NQ*AW-1:0] q_addr_low, q_addr_high;
   logic [NQ-1:0] q_enable, q_wrap, q_full;
`ifdef FIFO_TO_MEM_MQ_STATS_EN
   logic [NQ*32-1:0] wrc, drc;
`endif
   int total = 0, bad = 0;
   fifo_to_mem_mq dut (
      .clk(clk), .rst(rst), .sw_rst(sw_rst), .cal_done(cal_done),
      .fifo_rd_en(fifo_rd_en), .fifo_data(fifo_data), .fifo_qid(fifo_qid), .fifo_empty(fifo_empty),
      .mem_ad_w_n(mem_ad_w_n), .mem_wr_full(mem_wr_full), .mem_ad_wr(mem_ad_wr), .mem_d_w_n(mem_d_w_n),
      .mem_bwh_n(mem_bwh_n), .mem_bwl_n(mem_bwl_n), .mem_dwl(mem_dwl), .mem_dwh(mem_dwh),
`ifdef FIFO_TO_MEM_MQ_STATS_EN
      .q_wr_count(wrc), .q_drop_count(drc),
`endif
      .q_addr_low(q_addr_low), .q_addr_high(q_addr_high), .q_enable(q_enable), .q_wrap(q_wrap),
      .q_full(q_full)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic strobes(input string tag, input logic adwn, input logic [AW-1:0] ad, input logic dwn);
      chk({tag, "_adwn"}, 80'(mem_ad_w_n), 80'(adwn));
      if (!adwn) chk({tag, "_addr"}, 80'(mem_ad_wr), 80'(ad));
      chk({tag, "_dwn"}, 80'(mem_d_w_n), 80'(dwn));
   endtask
   task automatic beat(input logic [2:0] q, input logic [FW-1:0] d);
      fifo_qid = q;
      fifo_data = d;
      fifo_empty = 1'b0;
      #1 chk("rd_en", 80'(fifo_rd_en), 80'd1);
      @(posedge clk);
      #1 fifo_empty = 1'b1;
   endtask
   task automatic idle();
      fifo_empty = 1'b1;
      @(posedge clk);
      #1;
   endtask
   initial begin
      rst = 1'b1; sw_rst = 1'b0; cal_done = 1'b1; fifo_empty = 1'b1; mem_wr_full = 1'b0;
      fifo_data = '0; fifo_qid = '0;
      q_addr_low = '0; q_addr_high = '0; q_wrap = '0; q_enable = 8'b0000_0011;
      q_addr_low[0*AW +: AW] = 19'h10; q_addr_high[0*AW +: AW] = 19'h12;
      q_addr_low[1*AW +: AW] = 19'h20; q_addr_high[1*AW +: AW] = 19'h30;
      q_addr_low[3*AW +: AW] = 19'h40; q_addr_high[3*AW +: AW] = 19'h48;
      @(posedge clk);
      #1;
      strobes("reset", 1'b1, '0, 1'b1);
      chk("reset_addr", 80'(mem_ad_wr), 80'd0);
      chk("reset_dwl", 80'(mem_dwl), 80'd0);
      chk("reset_dwh", 80'(mem_dwh), 80'd0);
      chk("reset_bw", 80'({mem_bwh_n, mem_bwl_n}), 80'd0);
      chk("reset_full", 80'(q_full), 80'd0);
      rst = 1'b0;
      beat(3'd0, {72'hA1, 72'hA0});
      strobes("pre_rst", 1'b0, 19'h10, 1'b0);
      chk("pre_rst_dwl", 80'(mem_dwl), 80'hA0);
      rst = 1'b1;
      #1;
      strobes("async_rst", 1'b1, '0, 1'b1);
      chk("async_rst_addr", 80'(mem_ad_wr), 80'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      beat(3'd0, {72'hB1, 72'hB0});
      strobes("post_rst_b0", 1'b0, 19'h10, 1'b0);
      beat(3'd0, {72'hC1, 72'hC0});
      strobes("post_rst_b1", 1'b1, '0, 1'b0);
      chk("post_rst_dwh", 80'(mem_dwh), 80'hC1);
      sw_rst = 1'b1;
      idle();
      sw_rst = 1'b0;
      strobes("sw_rst", 1'b1, '0, 1'b1);
      beat(3'd0, {72'hD1, 72'hD0});
      strobes("q0_b0", 1'b0, 19'h10, 1'b0);
      beat(3'd0, {72'hD3, 72'hD2});
      strobes("q0_b1", 1'b1, '0, 1'b0);
      chk("q0_b1_dwh", 80'(mem_dwh), 80'hD3);
      chk("q0_not_full", 80'(q_full), 80'd0);
      beat(3'd0, {72'hD5, 72'hD4});
      strobes("q0_b2", 1'b0, 19'h11, 1'b0);
      beat(3'd0, {72'hD7, 72'hD6});
      strobes("q0_b3", 1'b1, '0, 1'b0);
      chk("q0_b3_dwl", 80'(mem_dwl), 80'hD6);
      chk("q0_full", 80'(q_full), 80'h01);
      beat(3'd0, {72'hE1, 72'hE0});
      strobes("q0_drop0", 1'b1, '0, 1'b1);
      beat(3'd0, {72'hE3, 72'hE2});
      strobes("q0_drop1", 1'b1, '0, 1'b1);
      chk("q0_still_full", 80'(q_full), 80'h01);
      q_enable[0] = 1'b0;
      idle();
      chk("disable_clears_full", 80'(q_full), 80'd0);
      q_enable[0] = 1'b1;
      q_wrap[0] = 1'b1;
      beat(3'd0, {72'h0, 72'h60}); strobes("ring_b0", 1'b0, 19'h10, 1'b0);
      beat(3'd0, {72'h0, 72'h61}); strobes("ring_b1", 1'b1, '0, 1'b0);
      beat(3'd0, {72'h0, 72'h62}); strobes("ring_b2", 1'b0, 19'h11, 1'b0);
      beat(3'd0, {72'h0, 72'h63}); strobes("ring_b3", 1'b1, '0, 1'b0);
      beat(3'd0, {72'h0, 72'h64}); strobes("ring_b4", 1'b0, 19'h10, 1'b0);
      chk("ring_b4_dwl", 80'(mem_dwl), 80'h64);
      beat(3'd0, {72'h0, 72'h65}); strobes("ring_b5", 1'b1, '0, 1'b0);
      chk("ring_no_full", 80'(q_full), 80'd0);
      beat(3'd3, {72'h0, 72'h70}); strobes("q3_dis0", 1'b1, '0, 1'b1);
      beat(3'd3, {72'h0, 72'h71}); strobes("q3_dis1", 1'b1, '0, 1'b1);
      beat(3'd1, {72'hF1, 72'hF0});
      strobes("bp_b0", 1'b0, 19'h20, 1'b0);
      fifo_qid = 3'd1; fifo_data = {72'hF3, 72'hF2}; fifo_empty = 1'b0; mem_wr_full = 1'b1;
      #1 chk("bp_rd_en", 80'(fifo_rd_en), 80'd0);
      @(posedge clk);
      #1 strobes("bp_gap", 1'b1, '0, 1'b1);
      mem_wr_full = 1'b0;
      beat(3'd1, {72'hF3, 72'hF2});
      strobes("bp_b1", 1'b1, '0, 1'b0);
      chk("bp_b1_dwl", 80'(mem_dwl), 80'hF2);
      beat(3'd1, {72'h0, 72'h80});
      strobes("bp_next", 1'b0, 19'h21, 1'b0);
      cal_done = 1'b0;
      fifo_qid = 3'd1; fifo_data = {72'h0, 72'h81}; fifo_empty = 1'b0;
      #1 chk("cal_rd_en0", 80'(fifo_rd_en), 80'd0);
      @(posedge clk);
      #1 strobes("cal_wait0", 1'b1, '0, 1'b1);
      chk("cal_rd_en1", 80'(fifo_rd_en), 80'd0);
      @(posedge clk);
      #1 strobes("cal_wait1", 1'b1, '0, 1'b1);
      cal_done = 1'b1;
      beat(3'd1, {72'h0, 72'h81});
      strobes("cal_go", 1'b1, '0, 1'b0);
      chk("cal_go_dwl", 80'(mem_dwl), 80'h81);
      beat(3'd1, {72'h0, 72'h82});
      strobes("cal_next", 1'b0, 19'h22, 1'b0);
      idle();
      strobes("final_idle", 1'b1, '0, 1'b1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
